branch_resolve: RTL
===================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter CNT_W, default 16: width of each statistics counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall_i  input  1  pipeline stall; 1 = hold the ID slot and counters.
REQ-005 IF_branch_i  input  1  instruction in IF is a conditional branch.
REQ-006 IF_taken_i  input  1  prediction for the IF branch, from the saturating predictor.
REQ-007 IF_pc_i  input  32  PC of the IF instruction.
REQ-008 ID_rs1_i  input  32  rs1 operand at ID.
REQ-009 ID_rs2_i  input  32  rs2 operand at ID.
REQ-010 ID_funct3_i  input  3  branch funct3 at ID.
REQ-011 ID_imm_i  input  32  sign-extended branch offset at ID.
REQ-012 clear_i  input  1  synchronous counter clear.
REQ-013 ID_branch_o  output  1  valid branch resolving in ID; drives predictor ID_branch_i.
REQ-014 wrong_o  output  1  ID branch was mispredicted; drives predictor wrong_i.
REQ-015 redirect_o  output  1  fetch must restart at redirect_pc_o.
REQ-016 redirect_pc_o  output  32  corrected fetch PC.
REQ-017 flush_o  output  1  squash the instruction currently in IF.
REQ-018 branch_cnt_o  output  CNT_W  resolved-branch count.
REQ-019 mispred_cnt_o  output  CNT_W  misprediction count.

Function
REQ-020 The block SHALL hold an ID slot of id_valid, id_pc[31:0] and id_taken.
REQ-021 Slot update, rising edge, when stall_i=0 and wrong_o=0: id_valid<=IF_branch_i, id_pc<=IF_pc_i, id_taken<=IF_taken_i.
REQ-022 Slot update when stall_i=0 and wrong_o=1: id_valid<=0; id_pc and id_taken are don't-care.
REQ-023 Slot update when stall_i=1: the slot holds all values, even if wrong_o=1.
REQ-024 Comparison: eq = (ID_rs1_i == ID_rs2_i), a 32-bit compare.
REQ-025 actual_taken: funct3 000 (BEQ) gives eq; funct3 001 (BNE) gives !eq; every other funct3 gives 0.
REQ-026 ID_branch_o SHALL equal id_valid, combinationally.
REQ-027 wrong_o SHALL equal id_valid && (actual_taken != id_taken), combinationally, in the same cycle (zero latency).
REQ-028 redirect_o SHALL equal wrong_o.
REQ-029 flush_o SHALL equal wrong_o && !stall_i.
REQ-030 redirect_pc_o when wrong_o=1: id_pc+ID_imm_i if actual_taken, else id_pc+4; modulo 2^32, wrapping without error.
REQ-031 redirect_pc_o when wrong_o=0: 32'h0.
REQ-032 branch_cnt_o: increments by 1 on each edge with id_valid=1 and stall_i=0.
REQ-033 mispred_cnt_o: increments by 1 on each edge with wrong_o=1 and stall_i=0.
REQ-034 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-035 clear_i=1 SHALL set both counters to 0 at the next edge, with priority over any increment in that cycle, stall or not.
REQ-036 Back-to-back branches: a correctly predicted ID branch and a new IF branch in the same unstalled cycle SHALL both be handled; the IF branch enters the slot at the next edge.
REQ-037 A mispredicted ID branch coinciding with an IF branch SHALL drop the IF branch, so it is never resolved or counted.

Reset
REQ-038 While rst_n=0, immediately and without a clock: id_valid=0, id_pc=0, id_taken=0, both counters 0.
REQ-039 Consequently, while rst_n=0: ID_branch_o=0, wrong_o=0, redirect_o=0, flush_o=0, redirect_pc_o=0.
REQ-040 Reset deasserted mid-stall SHALL resume with an empty slot; no branch in flight before reset is resolved.

Verification
REQ-041 Cases the bench SHALL cover:
- IF_branch_i=1, IF_taken_i=0, IF_pc_i=0x100; next cycle funct3=000, rs1=rs2=5, imm=0x20 -> wrong_o=1, redirect_pc_o=0x120, flush_o=1; the slot is empty on the following cycle.
- Predicted taken at pc 0x200; BNE with rs1=rs2 -> wrong_o=1, redirect_pc_o=0x204.
- Correct prediction (taken, BEQ equal) -> wrong_o=0, redirect_pc_o=0, branch_cnt_o +1, mispred_cnt_o unchanged.
- Mispredict held 3 cycles with stall_i=1 -> wrong_o=1 throughout, flush_o=0, counters frozen; first unstalled edge -> mispred_cnt_o +1 and the slot clears.
- CNT_W=4 with 20 mispredicts -> both counters stay at 15; clear_i coinciding with a mispredict -> both counters 0.
- rst_n pulsed low between clock edges with a valid slot -> ID_branch_o and wrong_o fall immediately; pc 0xFFFFFFFC with imm=8 and actual taken -> redirect_pc_o=0x4.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch resolution in ID: compares operands, detects mispredictions, steers
// fetch redirect/flush and keeps saturating branch / misprediction statistics.
module branch_resolve #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             IF_branch_i,
  input  logic             IF_taken_i,
  input  logic [31:0]      IF_pc_i,
  input  logic [31:0]      ID_rs1_i,
  input  logic [31:0]      ID_rs2_i,
  input  logic [2:0]       ID_funct3_i,
  input  logic [31:0]      ID_imm_i,
  input  logic             clear_i,
  output logic             ID_branch_o,
  output logic             wrong_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_taken;

  logic        eq;
  logic        actual_taken;
  logic        wrong;
  logic [31:0] target_pc;

  always_comb begin
    eq = (ID_rs1_i == ID_rs2_i);
    case (ID_funct3_i)
      F3_BEQ:  actual_taken = eq;
      F3_BNE:  actual_taken = ~eq;
      default: actual_taken = 1'b0;
    endcase
  end

  assign wrong = id_valid && (actual_taken != id_taken);

  // Resolved direction picks the target; addition wraps modulo 2^32.
  assign target_pc = actual_taken ? (id_pc + ID_imm_i) : (id_pc + 32'd4);

  assign ID_branch_o   = id_valid;
  assign wrong_o       = wrong;
  assign redirect_o    = wrong;
  assign redirect_pc_o = wrong ? target_pc : 32'h0;
  assign flush_o       = wrong && !stall_i;

  // A mispredict squashes whatever sits in IF, so the slot empties instead of loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_pc    <= 32'h0;
      id_taken <= 1'b0;
    end else if (!stall_i) begin
      id_valid <= IF_branch_i && !wrong;
      id_pc    <= IF_pc_i;
      id_taken <= IF_taken_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (clear_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (!stall_i) begin
      if (id_valid && !(&branch_cnt_o))
        branch_cnt_o <= branch_cnt_o + 1'b1;
      if (wrong && !(&mispred_cnt_o))
        mispred_cnt_o <= mispred_cnt_o + 1'b1;
    end
  end

endmodule
